// File: rtl/regfile_bus_arbiter_if.sv
// Requester-side bus of the register-file arbiter: two request/ack channels
// plus the shared read-data return.
interface regfile_bus_arbiter_if #(
  parameter int D_SIZE = 8,
  parameter int A_SIZE = 2
) ();
  logic              req0;
  logic              rw0;
  logic [A_SIZE-1:0] addr0;
  logic [D_SIZE-1:0] wdata0;
  logic              ack0;
  logic              req1;
  logic              rw1;
  logic [A_SIZE-1:0] addr1;
  logic [D_SIZE-1:0] wdata1;
  logic              ack1;
  logic [D_SIZE-1:0] rdata;

  modport slave (
    input  req0, rw0, addr0, wdata0,
    input  req1, rw1, addr1, wdata1,
    output ack0, ack1, rdata
  );

  modport master (
    output req0, rw0, addr0, wdata0,
    output req1, rw1, addr1, wdata1,
    input  ack0, ack1, rdata
  );
endinterface

// File: rtl/regfile_bus_arbiter.sv
// Two-requester arbiter for the 4-entry register-file bus: IDLE -> ACCESS -> RELEASE.
// Define ARB_RR_EN for round-robin tie-breaking; otherwise requester 0 wins ties.
module regfile_bus_arbiter #(
  parameter int D_SIZE = 8,
  parameter int A_SIZE = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  regfile_bus_arbiter_if.slave  bus,
  output logic                  ce,
  output logic                  rw,
  output logic [A_SIZE-1:0]     address,
  inout  wire  [D_SIZE-1:0]     data
);

  typedef enum logic [1:0] {IDLE, ACCESS, RELEASE} state_e;

  state_e            state_q, state_d;
  logic              grant_q, grant_d;
  logic              rw_q, rw_d;
  logic [A_SIZE-1:0] addr_q, addr_d;
  logic [D_SIZE-1:0] wdata_q, wdata_d;
  logic [D_SIZE-1:0] rdata_q, rdata_d;
  logic              anyReq;
  logic              tieWinner;
  logic              winner;
  logic              driveData;

  assign anyReq = bus.req0 | bus.req1;

`ifdef ARB_RR_EN
  logic lastGrant_q;

  // Remembers who was served last so a tie goes to the other requester.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lastGrant_q <= 1'b1;
    end else if (state_q == ACCESS) begin
      lastGrant_q <= grant_q;
    end
  end

  assign tieWinner = ~lastGrant_q;
`else
  assign tieWinner = 1'b0;
`endif

  assign winner = bus.req1 & (~bus.req0 | tieWinner);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (anyReq) state_d = ACCESS;
      ACCESS:  state_d = RELEASE;
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request is latched only in IDLE, so requesters may drop req once granted.
  always_comb begin
    grant_d = grant_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    if (state_q == IDLE && anyReq) begin
      grant_d = winner;
      rw_d    = winner ? bus.rw1    : bus.rw0;
      addr_d  = winner ? bus.addr1  : bus.addr0;
      wdata_d = winner ? bus.wdata1 : bus.wdata0;
    end
    if (state_q == ACCESS && !rw_q) begin
      rdata_d = data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      grant_q <= 1'b0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      grant_q <= grant_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    ce        = (state_q == ACCESS);
    rw        = rw_q;
    address   = addr_q;
    driveData = (state_q == ACCESS) && rw_q;
    bus.ack0  = (state_q == RELEASE) && !grant_q;
    bus.ack1  = (state_q == RELEASE) && grant_q;
    bus.rdata = rdata_q;
  end

  // The bus is released in RELEASE so the register file can float its read output.
  assign data = driveData ? wdata_q : {D_SIZE{1'bz}};

endmodule
